// File: rtl/float_pack.sv
// Packs a signed exponent and an unnormalized significand into an IEEE-754 single.
// The significand is normalized by one shift per cycle, then truncated toward zero.
module float_pack #(
    parameter logic [2:0] ZERO      = 3'b000,
    parameter logic [2:0] INF       = 3'b001,
    parameter logic [2:0] SUBNORMAL = 3'b010,
    parameter logic [2:0] NORMAL    = 3'b011,
    parameter logic [2:0] NAN       = 3'b100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [23:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_type
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DENORM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [10:0] exp_q, exp_d;
    logic [23:0]        mant_q, mant_d;
    logic [31:0]        data_q, data_d;
    logic [2:0]         type_q, type_d;
    logic [31:0]        fin_data;
    logic [2:0]         fin_type;

    // Final encoding of the working sign/exponent/significand.
    always_comb begin
        fin_data = {sign_q, 8'h00, mant_q[22:0]};
        fin_type = SUBNORMAL;
        if (mant_q == 24'd0) begin
            fin_data = {sign_q, 31'd0};
            fin_type = ZERO;
        end else if (mant_q[23] && exp_q >= 11'sd255) begin
            fin_data = {sign_q, 8'hFF, 23'd0};
            fin_type = INF;
        end else if (mant_q[23]) begin
            fin_data = {sign_q, exp_q[7:0], mant_q[22:0]};
            fin_type = NORMAL;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        data_d  = data_q;
        type_d  = type_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {in_exp[9], in_exp};
                    mant_d  = in_mant;
                    state_d = DONE;
                    if (in_type == ZERO) begin
                        data_d = {in_sign, 31'd0};
                        type_d = ZERO;
                    end else if (in_type == INF) begin
                        data_d = {in_sign, 8'hFF, 23'd0};
                        type_d = INF;
                    end else if (in_type == NORMAL || in_type == SUBNORMAL) begin
                        if (in_mant == 24'd0) begin
                            data_d = {in_sign, 31'd0};
                            type_d = ZERO;
                        end else begin
                            state_d = NORM;
                        end
                    end else begin
                        // Reserved codes are reported as quiet NaN.
                        data_d = {in_sign, 8'hFF, 23'h400000};
                        type_d = NAN;
                    end
                end
            end
            NORM: begin
                if (exp_q < 11'sd1) begin
                    state_d = DENORM;
                end else if (mant_q[23] || exp_q == 11'sd1) begin
                    data_d  = fin_data;
                    type_d  = fin_type;
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[22:0], 1'b0};
                    exp_d  = exp_q - 11'sd1;
                end
            end
            DENORM: begin
                if (mant_q == 24'd0 || exp_q >= 11'sd1) begin
                    data_d  = fin_data;
                    type_d  = fin_type;
                    state_d = DONE;
                end else begin
                    mant_d = {1'b0, mant_q[23:1]};
                    exp_d  = exp_q + 11'sd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            data_q  <= '0;
            type_q  <= ZERO;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            data_q  <= data_d;
            type_q  <= type_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_type  = type_q;

endmodule

// File: tb/tb_float_pack.sv
// Directed bench for float_pack: result words, classes, latencies,
// back-pressure hold and asynchronous reset mid-normalization.
module tb_float_pack;

    localparam logic [2:0] T_ZERO = 3'b000;
    localparam logic [2:0] T_INF  = 3'b001;
    localparam logic [2:0] T_SUB  = 3'b010;
    localparam logic [2:0] T_NORM = 3'b011;
    localparam logic [2:0] T_NAN  = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = 3'b0;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = 10'd0;
    logic [23:0] in_mant = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_type;

    int tests = 0;
    int fails = 0;

    float_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_type  (out_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Drives one request, waits for the result and checks it.
    task automatic run(input string tag, input logic [2:0] t, input logic s,
                       input int e, input logic [23:0] m,
                       input logic [31:0] xd, input logic [2:0] xt,
                       input int xlat, input int hold);
        int lat;
        logic [31:0] held;
        logic [31:0] ev;
        ev = e;
        in_valid = 1'b1;
        in_type  = t;
        in_sign  = s;
        in_exp   = ev[9:0];
        in_mant  = m;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_type  = T_ZERO;
        in_sign  = ~s;
        in_exp   = 10'h155;
        in_mant  = 24'd0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"}, out_data, xd);
        chk({tag, ".type"}, {29'd0, out_type}, {29'd0, xt});
        chk({tag, ".lat"}, lat, xlat);
        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
            end
            chk({tag, ".hold_data"}, out_data, held);
            chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.data", out_data, 32'h0);
        chk("rst.type", {29'd0, out_type}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run("one", T_NORM, 1'b0, 127, 24'h800000, 32'h3F800000, T_NORM, 2, 0);
        run("two", T_NORM, 1'b0, 130, 24'h200000, 32'h40000000, T_NORM, 4, 0);
        run("sub", T_SUB, 1'b0, 0, 24'h800000, 32'h00400000, T_SUB, 4, 0);
        run("uflow", T_SUB, 1'b0, -30, 24'h000001, 32'h00000000, T_ZERO, 4, 0);
        run("oflow", T_NORM, 1'b1, 300, 24'h800000, 32'hFF800000, T_INF, 2, 0);
        run("nan", T_NAN, 1'b1, 5, 24'h123456, 32'hFFC00000, T_NAN, 1, 0);
        run("rsvd", 3'b110, 1'b1, 0, 24'h0, 32'hFFC00000, T_NAN, 1, 0);
        run("zero", T_ZERO, 1'b1, 77, 24'hFFFFFF, 32'h80000000, T_ZERO, 1, 0);
        run("inf", T_INF, 1'b0, 1, 24'h1, 32'h7F800000, T_INF, 1, 0);
        run("m0", T_NORM, 1'b1, 100, 24'h0, 32'h80000000, T_ZERO, 1, 0);
        run("e1", T_NORM, 1'b0, 1, 24'h000003, 32'h00000003, T_SUB, 2, 0);
        run("e255", T_NORM, 1'b0, 255, 24'h800000, 32'h7F800000, T_INF, 2, 0);
        run("e254", T_NORM, 1'b0, 254, 24'hC00000, 32'h7F400000, T_NORM, 2, 0);
        run("stop1", T_NORM, 1'b0, 3, 24'h100000, 32'h00400000, T_SUB, 4, 0);
        run("emin", T_NORM, 1'b1, -512, 24'h800000, 32'h80000000, T_ZERO, 27, 0);
        run("hold", T_NORM, 1'b1, 127, 24'h800000, 32'hBF800000, T_NORM, 2, 5);

        // Reset asserted between edges while the block is still shifting.
        in_valid = 1'b1;
        in_type  = T_NORM;
        in_sign  = 1'b0;
        in_exp   = 10'd130;
        in_mant  = 24'h000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.ready", {31'd0, in_ready}, 32'd1);
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.data", out_data, 32'h0);
        chk("arst.type", {29'd0, out_type}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("post", T_NORM, 1'b0, 128, 24'hA00000, 32'h40200000, T_NORM, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/float_pack.md
FLOAT_PACK -- requirements
Module: float_pack

Interface
REQ-001 The block SHALL have parameter ZERO, default 3'b000, type code for signed zero.
REQ-002 The block SHALL have parameter INF, default 3'b001, type code for infinity.
REQ-003 The block SHALL have parameter SUBNORMAL, default 3'b010, type code for subnormal.
REQ-004 The block SHALL have parameter NORMAL, default 3'b011, type code for normal.
REQ-005 The block SHALL have parameter NAN, default 3'b100, type code for NaN; codes 3'b101..3'b111 are reserved.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 in_valid  input  1  request valid.
REQ-010 in_ready  output  1  block can accept a request.
REQ-011 in_type  input  3  requested result class, using the parameter codes.
REQ-012 in_sign  input  1  result sign.
REQ-013 in_exp  input  10  signed two's-complement biased exponent, range -512..511.
REQ-014 in_mant  input  24  unnormalized significand; bit 23 is the hidden-bit position.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_data  output  32  IEEE-754 single-precision word {sign, exp[7:0], frac[22:0]}.
REQ-018 out_type  output  3  class of out_data, using the parameter codes.

Function
REQ-019 The block SHALL use FSM states IDLE, NORM, DENORM and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-020 In IDLE with in_valid=1, the block SHALL capture sign, exp and mant and classify on that edge.
REQ-021 Classification: ZERO -> DONE with {s,0x00,0}; INF -> DONE with {s,0xFF,0}; NAN or a reserved code -> DONE with {s,0xFF,0x400000}, out_type NAN.
REQ-022 Classification: NORMAL or SUBNORMAL with in_mant=0 -> DONE as ZERO; otherwise -> NORM.
REQ-023 NORM, evaluated in priority order, one step per cycle: exp<1 -> DENORM; mant[23]=1 -> finalize; exp=1 -> finalize; else mant<<=1 and exp-=1 (stay in NORM).
REQ-024 DENORM, one step per cycle: mant=0 -> finalize; exp>=1 -> finalize; else mant>>=1 (truncate, round toward zero) and exp+=1.
REQ-025 Finalize (transition to DONE) rule 1: mant=0 -> {s,0,0}, out_type ZERO.
REQ-026 Finalize rule 2: mant[23]=1 and exp>=255 -> {s,0xFF,0}, out_type INF.
REQ-027 Finalize rule 3: mant[23]=1 and 1<=exp<=254 -> {s,exp[7:0],mant[22:0]}, out_type NORMAL.
REQ-028 Finalize rule 4: mant[23]=0 -> {s,0x00,mant[22:0]}, out_type SUBNORMAL.
REQ-029 The internal exponent SHALL be at least 11 bits signed so that increments and decrements never wrap.
REQ-030 Latency: ZERO, INF and NAN results SHALL assert out_valid 1 cycle after acceptance.
REQ-031 Latency: an in-range, already-normalized input SHALL assert out_valid 2 cycles after acceptance; each shift adds 1 cycle, and the NORM-to-DENORM transition adds 1 cycle.
REQ-032 DONE SHALL hold out_data and out_type stable until out_valid and out_ready are both 1 on an edge, then return to IDLE; throughput is 1 request per transaction, with no overlap.
REQ-033 in_type, in_exp and in_mant SHALL be ignored outside IDLE.

Reset
REQ-034 While rst_n=0, regardless of state, the block SHALL immediately force: state IDLE, in_ready=1, out_valid=0, out_data=32'h0, out_type=ZERO, internal registers cleared.
REQ-035 Any in-flight request SHALL be discarded on reset, and the first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-036 NORMAL, s=0, exp=127, mant=0x800000 -> out_data 0x3F800000, out_type NORMAL, latency 2.
REQ-037 NORMAL, s=0, exp=130, mant=0x200000 -> two left shifts, out_data 0x40000000, latency 4.
REQ-038 SUBNORMAL, s=0, exp=0, mant=0x800000 -> DENORM one shift, out_data 0x00400000, out_type SUBNORMAL, latency 4; exp=-30, mant=0x000001 -> out_data 0x00000000, out_type ZERO.
REQ-039 NORMAL, s=1, exp=300, mant=0x800000 -> out_data 0xFF800000, out_type INF, latency 2.
REQ-040 NAN, s=1, and in_type=3'b110 -> out_data 0xFFC00000, out_type NAN, latency 1.
REQ-041 out_ready held at 0 for 5 cycles in DONE -> out_data stable, in_ready=0; rst_n pulsed low mid-NORM -> all outputs at reset values with no clock edge, and the next request completes correctly.
